// File: rtl/shift_link_pkg.sv
// Shared definitions for the 4-bit right-shift serial link: state encoding,
// default link width and the bit-counter width helper.
package shift_link_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int LINK_WIDTH = 4;

    // A one-bit counter is the floor so WIDTH=2 still gets a usable register.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_tx_piso_if.sv
// Word-load handshake and serial-line signals of the PISO transmitter.
// The word source holds the master side; the transmitter holds the slave side.
interface shift_tx_piso_if
    import shift_link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
);

    logic [WIDTH-1:0] D;
    logic             LOAD;
    logic             READY;
    logic             Dout;
    logic             VALID;
    logic             DONE;

    modport master (
        output D,
        output LOAD,
        input  READY,
        input  Dout,
        input  VALID,
        input  DONE
    );

    modport slave (
        input  D,
        input  LOAD,
        output READY,
        output Dout,
        output VALID,
        output DONE
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the transmitter: counts shifts within a frame,
// saturates at WIDTH-1 and flags the last bit.
module piso_bit_counter
    import shift_link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_tx_piso.sv
// Parallel-in/serial-out transmitter: captures a WIDTH-bit word on LOAD&&READY
// and sends it LSB-first on Dout with VALID, pulsing DONE on the last bit.
module shift_tx_piso
    import shift_link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    shift_tx_piso_if.slave        bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic             last;
    logic             accept;
    logic             ready;
    logic             valid;
    logic             dout;
    logic             done;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clear (accept),
        .en    (state == ST_SHIFT),
        .last  (last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode only registered state; LOAD steers just the next state.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready     = 1'b1;
        valid     = 1'b0;
        dout      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = bus.LOAD;
                if (bus.LOAD) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                valid = 1'b1;
                dout  = sreg[0];
                ready = last;
                done  = last;
                if (last) begin
                    accept    = bus.LOAD;
                    state_nxt = bus.LOAD ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // D is captured only on the accepting edge; the frame in flight is immune to D.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= bus.D;
        end else if (state == ST_SHIFT) begin
            sreg <= sreg >> 1;
        end
    end

    assign bus.READY = ready;
    assign bus.VALID = valid;
    assign bus.Dout  = dout;
    assign bus.DONE  = done;

endmodule
